// File: rtl/ccu_pkg.sv
// Shared constants, FSM state encoding and frame helpers for the coincidence-counting readout scheduler.
package ccu_pkg;

    localparam int          NUM_CH      = 9;
    localparam int          FRAME_LEN   = NUM_CH + 3;
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;
    localparam logic [3:0]  SEL_NONE    = 4'hF;
    localparam logic [3:0]  LAST_IDX    = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        SEQ    = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4
    } state_e;

    // Pick one channel byte out of the flattened snapshot.
    function automatic logic [7:0] snap_byte(input logic [8*NUM_CH-1:0] snap,
                                             input logic [3:0]          idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 4'(i)) begin
                b = snap[8*i +: 8];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Trailing frame byte: XOR of the sequence number and every channel byte.
    function automatic logic [7:0] frame_checksum(input logic [7:0]          seq,
                                                  input logic [8*NUM_CH-1:0] snap);
        logic [7:0] c;
        c = seq;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c ^ snap[8*i +: 8];
        end
        return c;
    endfunction

endpackage

// File: rtl/ccu_readout_scheduler_if.sv
// Byte stream from the readout scheduler to the UART transmitter (valid/ready handshake).
interface ccu_readout_scheduler_if;
    import ccu_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] selection;
    logic       frame_active;

    modport master (
        output tx_data,
        output tx_valid,
        output selection,
        output frame_active,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  selection,
        input  frame_active,
        output tx_ready
    );

endinterface

// File: rtl/ccu_window_timer.sv
// Measurement window timer: counts 0..WINDOW_CYCLES-1 while enabled and flags the last cycle.
module ccu_window_timer #(
    parameter int WINDOW_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic window_end
);
    import ccu_pkg::*;

    localparam int               CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    // Next count and window-end decode; reset masks the strobe so it cannot leak into a reset cycle.
    always_comb begin
        at_last    = (cnt_q == LAST);
        window_end = enable & at_last & ~rst;
        if (!enable) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ccu_readout_scheduler.sv
// Per-window snapshot of the channel counters and framed, checksummed streaming of it to the UART.
module ccu_readout_scheduler
    import ccu_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [8*NUM_CH-1:0]   counts_flat,
    output logic                  batch_done,
    ccu_readout_scheduler_if.master tx,
    output logic                  overrun,
    output logic [7:0]            dropped_cnt
);

    state_e              state_q,    state_d;
    logic [3:0]          idx_q,      idx_d;
    logic [7:0]          seq_q,      seq_d;
    logic [8*NUM_CH-1:0] snap_q,     snap_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [3:0]          sel_q,      sel_d;
    logic [7:0]          dropped_q,  dropped_d;

    logic window_end;
    logic xfer;
    logic start_frame;
    logic overrun_c;
    logic [3:0] idx_nx;

    ccu_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .window_end (window_end)
    );

    assign xfer   = tx_valid_q & tx.tx_ready;
    assign idx_nx = idx_q + 4'd1;

    // Frame sequencer: each state owns the byte currently offered and advances only on a transfer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        snap_d      = snap_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        sel_d       = sel_q;
        dropped_d   = dropped_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (window_end) begin
                    start_frame = 1'b1;
                end else begin
                    start_frame = 1'b0;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_d   = SEQ;
                    tx_data_d = seq_q;
                end else begin
                    state_d   = HEADER;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_d   = DATA;
                    idx_d     = 4'd0;
                    tx_data_d = snap_byte(snap_q, 4'd0);
                    sel_d     = 4'd0;
                end else begin
                    state_d   = SEQ;
                end
            end
            DATA: begin
                if (xfer && (idx_q == LAST_IDX)) begin
                    state_d   = CHECK;
                    idx_d     = 4'd0;
                    tx_data_d = frame_checksum(seq_q, snap_q);
                    sel_d     = SEL_NONE;
                end else if (xfer) begin
                    idx_d     = idx_nx;
                    tx_data_d = snap_byte(snap_q, idx_nx);
                    sel_d     = idx_nx;
                end else begin
                    state_d   = DATA;
                end
            end
            CHECK: begin
                if (xfer) begin
                    seq_d = seq_q + 8'd1;
                    // A window ending on the very cycle the checksum leaves starts the next frame back-to-back.
                    if (window_end) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = 4'd0;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
                sel_d      = SEL_NONE;
            end
        endcase

        // Any window end that cannot start a frame discards its batch.
        overrun_c = window_end & ~start_frame;

        if (start_frame) begin
            snap_d     = counts_flat;
            state_d    = HEADER;
            tx_valid_d = 1'b1;
            tx_data_d  = HEADER_BYTE;
            sel_d      = SEL_NONE;
        end else begin
            snap_d     = snap_d;
        end

        if (overrun_c && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            seq_q      <= 8'h00;
            snap_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            sel_q      <= SEL_NONE;
            dropped_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            sel_q      <= sel_d;
            dropped_q  <= dropped_d;
        end
    end

    assign tx.tx_data      = tx_data_q;
    assign tx.tx_valid     = tx_valid_q;
    assign tx.selection    = sel_q;
    assign tx.frame_active = (state_q != IDLE);
    assign batch_done      = window_end;
    assign overrun         = overrun_c;
    assign dropped_cnt     = dropped_q;

endmodule

// File: tb/tb_ccu_readout_scheduler.sv
// Randomized bench for ccu_readout_scheduler against a queue-of-bytes frame model.
module tb_ccu_readout_scheduler;
    import ccu_pkg::*;

    localparam int W = 16;

    logic                clk;
    logic                rst;
    logic                enable;
    logic [8*NUM_CH-1:0] counts_flat;
    logic                batch_done;
    logic                overrun;
    logic [7:0]          dropped_cnt;

    ccu_readout_scheduler_if ifc ();

    ccu_readout_scheduler #(.WINDOW_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .counts_flat (counts_flat),
        .batch_done  (batch_done),
        .tx          (ifc.master),
        .overrun     (overrun),
        .dropped_cnt (dropped_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending frame bytes with their selection and frame position.
    logic [7:0] mq[$];
    logic [3:0] msq[$];
    int         mpq[$];
    int         tmr;
    logic [7:0] mseq;
    int         mdrop;
    int         coinc;

    logic [7:0] rx[$];
    int n_tests, n_fail;
    int cyc, bd_first, bd_cnt;
    logic [7:0] last_seq;
    bit wrap_seen;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic build_frame(input logic [8*NUM_CH-1:0] cv);
        logic [7:0] cs;
        cs = mseq;
        mq.push_back(HEADER_BYTE); msq.push_back(4'hF); mpq.push_back(0);
        mq.push_back(mseq);        msq.push_back(4'hF); mpq.push_back(1);
        for (int i = 0; i < NUM_CH; i++) begin
            mq.push_back(cv[8*i +: 8]); msq.push_back(4'(i)); mpq.push_back(i + 2);
            cs = cs ^ cv[8*i +: 8];
        end
        mq.push_back(cs); msq.push_back(4'hF); mpq.push_back(FRAME_LEN - 1);
    endtask

    task automatic step(input logic r, input logic e, input logic rd, input logic [8*NUM_CH-1:0] cv);
        int   n;
        logic bd_e, ov_e;
        rst = r; enable = e; ifc.tx_ready = rd; counts_flat = cv;
        @(negedge clk);
        n    = mq.size();
        bd_e = !r && e && (tmr == W - 1);
        ov_e = bd_e && !((n == 0) || (n == 1 && rd));
        check_eq("tx_valid",     ifc.tx_valid,     (n > 0));
        check_eq("tx_data",      ifc.tx_data,      (n > 0) ? mq[0] : 8'h00);
        check_eq("selection",    ifc.selection,    (n > 0) ? msq[0] : 4'hF);
        check_eq("frame_active", ifc.frame_active, (n > 0));
        check_eq("batch_done",   batch_done,       bd_e);
        check_eq("overrun",      overrun,          ov_e);
        check_eq("dropped_cnt",  dropped_cnt,      mdrop);
        if (batch_done) begin
            bd_cnt++;
            if (bd_first < 0) bd_first = cyc;
        end
        if (!r && ifc.tx_valid && rd) rx.push_back(ifc.tx_data);
        if (!r && n > 0 && rd && mpq[0] == 1) begin
            if (last_seq == 8'hFF && ifc.tx_data == 8'h00) wrap_seen = 1'b1;
            last_seq = ifc.tx_data;
        end
        cyc++;
        @(posedge clk);
        if (r) begin
            mq.delete(); msq.delete(); mpq.delete();
            tmr = 0; mseq = 8'h00; mdrop = 0;
        end else begin
            if (n > 0 && rd) begin
                void'(mq.pop_front()); void'(msq.pop_front()); void'(mpq.pop_front());
                if (n == 1) mseq = mseq + 8'd1;
            end
            if (bd_e) begin
                if (n == 1 && rd) coinc++;
                if (mq.size() == 0) build_frame(cv);
                else if (mdrop < 255) mdrop++;
            end
            tmr = (!e || tmr == W - 1) ? 0 : tmr + 1;
        end
        #1;
    endtask

    function automatic logic [8*NUM_CH-1:0] rnd_counts();
        logic [8*NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    logic [8*NUM_CH-1:0] nom_cv;
    logic [7:0]          nom[FRAME_LEN];
    int                  guard;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; bd_first = -1; bd_cnt = 0;
        coinc = 0; last_seq = 8'h00; wrap_seen = 1'b0;
        tmr = 0; mseq = 8'h00; mdrop = 0;
        rst = 1'b1; enable = 1'b1; ifc.tx_ready = 1'b1; counts_flat = '0;
        for (int i = 0; i < NUM_CH; i++) nom_cv[8*i +: 8] = 8'(i + 1);
        nom[0] = 8'hA5; nom[1] = 8'h00;
        for (int i = 0; i < NUM_CH; i++) nom[i + 2] = 8'(i + 1);
        nom[FRAME_LEN - 1] = 8'h01;
        @(posedge clk); #1;

        // Reset state
        step(1'b1, 1'b1, 1'b1, nom_cv);
        step(1'b1, 1'b1, 1'b1, nom_cv);
        check_eq("rst_valid", ifc.tx_valid, 1'b0);
        check_eq("rst_sel",   ifc.selection, 4'hF);
        check_eq("rst_data",  ifc.tx_data, 8'h00);

        // Nominal frame and next-frame sequence number
        rx.delete(); cyc = 0; bd_first = -1;
        for (int c = 0; c < 48; c++) step(1'b0, 1'b1, 1'b1, nom_cv);
        check_eq("bd_cycle", bd_first, W - 1);
        check_eq("nom_len", (rx.size() >= 2 * FRAME_LEN), 1'b1);
        for (int k = 0; k < FRAME_LEN; k++) check_eq($sformatf("nom_byte%0d", k), rx[k], nom[k]);
        check_eq("nom2_hdr", rx[FRAME_LEN], 8'hA5);
        check_eq("nom2_seq", rx[FRAME_LEN + 1], 8'h01);
        check_eq("nom2_chk", rx[2 * FRAME_LEN - 1], 8'h00);

        // Backpressure: ready high one cycle in three on average
        for (int c = 0; c < 300; c++) step(1'b0, 1'b1, ($urandom_range(0, 2) == 0), rnd_counts());

        // Overrun: stall a freshly started frame for 40 cycles
        step(1'b1, 1'b1, 1'b1, nom_cv);
        guard = 0;
        while (mq.size() == 0 && guard < 64) begin
            step(1'b0, 1'b1, 1'b1, rnd_counts());
            guard++;
        end
        check_eq("ovr_start_timeout", (mq.size() > 0), 1'b1);
        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 1'b0, rnd_counts());
        check_eq("ovr_dropped", dropped_cnt, 8'd2);
        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 1'b1, rnd_counts());

        // Hold the checksum byte until it lands on a window end
        for (int c = 0; c < 200; c++)
            step(1'b0, 1'b1, (mq.size() != 1) || (tmr == W - 1), rnd_counts());
        check_eq("coincident_seen", (coinc > 0), 1'b1);

        // Enable low, then enough frames to wrap the sequence number
        bd_cnt = 0;
        for (int c = 0; c < 200; c++) step(1'b0, 1'b0, 1'b1, rnd_counts());
        check_eq("disabled_bd", bd_cnt, 0);
        for (int c = 0; c < 257 * W + W; c++) step(1'b0, 1'b1, 1'b1, rnd_counts());
        check_eq("seq_wrap", wrap_seen, 1'b1);

        // Reset in the middle of the data bytes
        guard = 0;
        while (!(mq.size() > 0 && mpq[0] == 5) && guard < 100) begin
            step(1'b0, 1'b1, 1'b1, rnd_counts());
            guard++;
        end
        check_eq("mid_data_timeout", (mq.size() > 0 && mpq[0] == 5), 1'b1);
        step(1'b1, 1'b1, 1'b1, rnd_counts());
        check_eq("mid_rst_valid",   ifc.tx_valid, 1'b0);
        check_eq("mid_rst_sel",     ifc.selection, 4'hF);
        check_eq("mid_rst_dropped", dropped_cnt, 8'h00);
        rx.delete(); guard = 0;
        while (rx.size() < 2 && guard < 60) begin
            step(1'b0, 1'b1, 1'b1, rnd_counts());
            guard++;
        end
        check_eq("post_rst_hdr", rx[0], 8'hA5);
        check_eq("post_rst_seq", rx[1], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
